inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch-stage PC register and a block-wide backing memory. Replaces the combinational instruction memory: it returns the 32-bit instruction for the current PC on a hit in the same cycle. On a miss it stalls fetch and runs a one-line refill over the same ready/read handshake the data-side memory uses. It has no write path; instruction memory is never modified at run time.

---
 rtl/icache_pkg.sv | 19 +
 rtl/inst_cache_if.sv | 29 ++
 rtl/icache_line_array.sv | 47 ++++
 rtl/inst_cache.sv | 146 ++++++++++++++
 tb/tb_inst_cache.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache.
package icache_pkg;

  localparam int LINE_BITS      = 128;
  localparam int OFFSET_BITS    = 4;
  localparam int WORDS_PER_LINE = 4;

  // Refill controller states.
  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } stateT;

  // Line-aligned address: clears the byte offset within a 16-byte line.
  function automatic logic [31:0] lineAddr(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Refill bus between the instruction cache and the backing memory.
//
// Handshake: the cache (master) raises mem_read with mem_addr and holds both
// until it samples mem_ready = 1 on a rising edge. The memory (slave) keeps
// data_from_mem stable while mem_ready is high. mem_read drops in the cycle
// after acceptance. mem_ready seen while mem_read is low has no effect.
interface inst_cache_if;
  import icache_pkg::*;

  logic                 mem_read;
  logic [31:0]          mem_addr;
  logic                 mem_ready;
  logic [LINE_BITS-1:0] data_from_mem;

  modport master (
    output mem_read,
    output mem_addr,
    input  mem_ready,
    input  data_from_mem
  );

  modport slave (
    input  mem_read,
    input  mem_addr,
    output mem_ready,
    output data_from_mem
  );

endinterface

// File: rtl/icache_line_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// One combinational read port, one synchronous write port. Valid bits clear
// on reset; tag and data contents are don't-care while invalid.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int TAG_BITS  = 22
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_LINES)-1:0] rdIndex,
  output logic                         rdValid,
  output logic [TAG_BITS-1:0]          rdTag,
  output logic [LINE_BITS-1:0]         rdData,
  input  logic                         wrEn,
  input  logic [$clog2(NUM_LINES)-1:0] wrIndex,
  input  logic [TAG_BITS-1:0]          wrTag,
  input  logic [LINE_BITS-1:0]         wrData
);

  logic [NUM_LINES-1:0] validArr;
  logic [TAG_BITS-1:0]  tagArr  [NUM_LINES];
  logic [LINE_BITS-1:0] dataArr [NUM_LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk) begin
    if (reset) begin
      validArr <= '0;
    end else if (wrEn) begin
      validArr[wrIndex] <= 1'b1;
    end
  end

  // Tag and data storage: written on fill, no reset needed.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagArr[wrIndex]  <= wrTag;
      dataArr[wrIndex] <= wrData;
    end
  end

  assign rdValid = validArr[rdIndex];
  assign rdTag   = tagArr[rdIndex];
  assign rdData  = dataArr[rdIndex];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache. Hits return the instruction in
// the same cycle; misses stall fetch and refill one 128-bit line over the
// inst_cache_if bus.
// Optional feature macro: INST_CACHE_STATS_EN adds saturating hit_count and
// miss_count outputs.
module inst_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [31:0]  pc,
  output logic [31:0]  instr,
  output logic         hit,
  output logic         icache_stall,
  inst_cache_if.master mem,
`ifdef INST_CACHE_STATS_EN
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
`endif
  output stateT        stateDbg
);

  localparam int IDX      = $clog2(NUM_LINES);
  localparam int TAG_BITS = 32 - IDX - OFFSET_BITS;

  stateT state;
  stateT stateNext;

  logic [31:0]          missPc;
  logic                 missStart;
  logic                 fill;

  logic [1:0]           offset;
  logic [IDX-1:0]       index;
  logic [TAG_BITS-1:0]  tag;
  logic [IDX-1:0]       missIndex;
  logic [TAG_BITS-1:0]  missTag;

  logic                 rdValid;
  logic [TAG_BITS-1:0]  rdTag;
  logic [LINE_BITS-1:0] rdData;
  logic [31:0]          wordSel;
  logic                 unusedBits;

  // Address split of the live fetch PC and of the latched miss PC.
  assign offset    = pc[3:2];
  assign index     = pc[IDX+OFFSET_BITS-1:OFFSET_BITS];
  assign tag       = pc[31:IDX+OFFSET_BITS];
  assign missIndex = missPc[IDX+OFFSET_BITS-1:OFFSET_BITS];
  assign missTag   = missPc[31:IDX+OFFSET_BITS];
  assign unusedBits = ^pc[1:0];

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_BITS  (TAG_BITS)
  ) u_lines (
    .clk     (clk),
    .reset   (reset),
    .rdIndex (index),
    .rdValid (rdValid),
    .rdTag   (rdTag),
    .rdData  (rdData),
    .wrEn    (fill & ~reset),
    .wrIndex (missIndex),
    .wrTag   (missTag),
    .wrData  (mem.data_from_mem)
  );

  // Hit only while idle; a refill in flight never reports a hit.
  assign hit = req & (state == IDLE) & rdValid & (rdTag == tag);

  // Word select within the resident line.
  always_comb begin
    wordSel = '0;
    case (offset)
      2'd0: wordSel = rdData[31:0];
      2'd1: wordSel = rdData[63:32];
      2'd2: wordSel = rdData[95:64];
      2'd3: wordSel = rdData[127:96];
      default: wordSel = '0;
    endcase
  end

  assign instr        = hit ? wordSel : 32'b0;
  assign icache_stall = (state == REFILL) | (req & ~hit);

  assign mem.mem_read = (state == REFILL);
  assign mem.mem_addr = lineAddr(missPc);
  assign stateDbg     = state;

  // State register and miss-PC latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      missPc <= '0;
    end else begin
      state <= stateNext;
      if (missStart) begin
        missPc <= pc;
      end
    end
  end

  // Next-state logic: miss detection in IDLE, fill completion in REFILL.
  always_comb begin
    stateNext = state;
    missStart = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          missStart = 1'b1;
          stateNext = REFILL;
        end
      end
      REFILL: begin
        if (mem.mem_ready) begin
          fill      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef INST_CACHE_STATS_EN
  // Saturating hit and miss event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (missStart && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Testbench for inst_cache: directed scenarios plus randomized fetch streams
// checked against a line-level reference model through an expected queue.
module tb_inst_cache;
  import icache_pkg::*;

  localparam int NUM_LINES = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  stalls;
    logic [7:0]  reads;
    logic [31:0] addr;
  } expT;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        hit;
  logic        icache_stall;
  stateT       stateDbg;
`ifdef INST_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  inst_cache_if memIf();

  inst_cache #(.NUM_LINES(NUM_LINES)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .pc           (pc),
    .instr        (instr),
    .hit          (hit),
    .icache_stall (icache_stall),
    .mem          (memIf),
`ifdef INST_CACHE_STATS_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .stateDbg     (stateDbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int  nVec  = 0;
  int  nFail = 0;
  expT expQ[$];
  bit  modelValid[NUM_LINES];
  int unsigned modelTag[NUM_LINES];
  int  expHits = 0;
  int  expMisses = 0;

  int          memDelay = 0;
  int          readCnt = 0;
  logic        forceReady = 1'b0;
  logic [31:0] forceAddr = '0;
  bit          monEn = 1'b0;
  int          stallRun = 0;
  int          readRun = 0;
  logic [31:0] firstAddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
  endtask

  // Backing-memory contents: line 0x40 holds 0xA..0xD, everything else hashed.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'h4) return 32'hA + {30'b0, w[3:2]};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] memLine(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'hF;
    return {memWord(b + 32'd12), memWord(b + 32'd8), memWord(b + 32'd4), memWord(b)};
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < NUM_LINES; i++) begin
      modelValid[i] = 1'b0;
      modelTag[i]   = 0;
    end
    expHits   = 0;
    expMisses = 0;
  endfunction

  // ---------------- backing memory responder ----------------
  initial begin
    memIf.mem_ready     = 1'b0;
    memIf.data_from_mem = '0;
    forever begin
      @(posedge clk);
      #1;
      if (forceReady) begin
        memIf.mem_ready     = 1'b1;
        memIf.data_from_mem = memLine(forceAddr);
      end else if (memIf.mem_read) begin
        if (readCnt == memDelay) begin
          memIf.mem_ready     = 1'b1;
          memIf.data_from_mem = memLine(memIf.mem_addr);
          readCnt = 0;
        end else begin
          memIf.mem_ready = 1'b0;
          readCnt++;
        end
      end else begin
        memIf.mem_ready = 1'b0;
        readCnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic doReset();
    reset = 1'b1;
    req   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelClear();
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one fetch, predict its outcome from the line model, hold it until accepted.
  task automatic fetch(input logic [31:0] a, input int d);
    expT         e;
    int          idx;
    int unsigned tg;
    bit          isHit;
    bit          done;
    idx   = int'((a / 32'd16) % NUM_LINES);
    tg    = a / (32'd16 * NUM_LINES);
    isHit = modelValid[idx] && (modelTag[idx] == tg);
    e.instr  = memWord(a);
    e.stalls = isHit ? 8'd0 : 8'(d + 2);
    e.reads  = isHit ? 8'd0 : 8'(d + 1);
    e.addr   = a & ~32'hF;
    if (!isHit) begin
      modelValid[idx] = 1'b1;
      modelTag[idx]   = tg;
      expMisses++;
    end
    expHits++;
    expQ.push_back(e);
    memDelay = d;
    req      = 1'b1;
    pc       = a;
    done     = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!icache_stall) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      nVec++;
      nFail++;
      $display("FAIL fetch_timeout: pc %h still stalled, required accept within 60 cycles", a);
      report();
      $finish;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    expT e;
    if (reset || !monEn) begin
      stallRun = 0;
      readRun  = 0;
    end else begin
      if (memIf.mem_read) begin
        if (readRun == 0) firstAddr = memIf.mem_addr;
        readRun++;
      end
      if (!req) begin
        check("idle_stall", 32'(icache_stall), 32'd0);
        check("idle_instr", instr, 32'd0);
      end else if (icache_stall) begin
        stallRun++;
        check("stall_hit", 32'(hit), 32'd0);
      end else begin
        if (expQ.size() == 0) begin
          nVec++;
          nFail++;
          $display("FAIL unexpected_accept: pc %h accepted with no fetch pending", pc);
        end else begin
          e = expQ.pop_front();
          check("instr", instr, e.instr);
          check("hit", 32'(hit), 32'd1);
          check("stall_cycles", 32'(stallRun), 32'(e.stalls));
          check("read_cycles", 32'(readRun), 32'(e.reads));
          if (e.reads != 8'd0) check("mem_addr", firstAddr, e.addr);
        end
        stallRun = 0;
        readRun  = 0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    nVec++;
    nFail++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] p;
    bit          done;
    reset = 1'b1;
    req   = 1'b0;
    pc    = '0;
    modelClear();
    repeat (3) @(posedge clk);
    #1;

    // Reset state with req low.
    @(negedge clk);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_mem_read", 32'(memIf.mem_read), 32'd0);
    check("rst_mem_addr", memIf.mem_addr, 32'd0);
    check("rst_stall_req0", 32'(icache_stall), 32'd0);
    check("rst_state", 32'(stateDbg), 32'(IDLE));
    @(posedge clk);
    #1;
    req = 1'b1;
    pc  = 32'h40;
    @(negedge clk);
    check("rst_stall_req1", 32'(icache_stall), 32'd1);
    check("rst_hit_req1", 32'(hit), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 1'b0;
    monEn = 1'b1;

    // Cold miss, then same-line hits.
    fetch(32'h40, 3);
    fetch(32'h44, 0);
    fetch(32'h48, 0);
    fetch(32'h4C, 0);
`ifdef INST_CACHE_STATS_EN
    check("stats_miss_1", miss_count, 32'd1);
    check("stats_hit_4", hit_count, 32'd4);
`endif

    // Conflict eviction and immediate ready.
    fetch(32'h440, 2);
    fetch(32'h40, 1);
    fetch(32'h840, 0);
    idle(2);
    fetch(32'h844, 0);

    // Randomized fetch stream over a few tags/indices to force reuse and conflicts.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
          32'($urandom_range(0, 15));
      fetch(a, $urandom_range(0, 3));
    end
`ifdef INST_CACHE_STATS_EN
    check("stats_miss", miss_count, 32'(expMisses));
    check("stats_hit", hit_count, 32'(expHits));
`endif

    // Reset in the middle of a refill.
    monEn    = 1'b0;
    p        = 32'h0001_2340;
    memDelay = 20;
    req      = 1'b1;
    pc       = p;
    @(negedge clk);
    check("mr_stall", 32'(icache_stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mr_mem_read", 32'(memIf.mem_read), 32'd1);
    check("mr_mem_addr", memIf.mem_addr, p & ~32'hF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    check("mr_read_drop", 32'(memIf.mem_read), 32'd0);
    check("mr_state", 32'(stateDbg), 32'(IDLE));
    forceAddr  = p;
    forceReady = 1'b1;
    @(negedge clk);
    check("mr_late_ready_seen", 32'(memIf.mem_ready), 32'd1);
    check("mr_late_read", 32'(memIf.mem_read), 32'd0);
    forceReady = 1'b0;
    @(negedge clk);
    check("mr_late_state", 32'(stateDbg), 32'(IDLE));
    req      = 1'b1;
    pc       = p;
    memDelay = 1;
    #1;
    check("mr_refetch_hit", 32'(hit), 32'd0);
    check("mr_refetch_stall", 32'(icache_stall), 32'd1);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!icache_stall) done = 1'b1;
    end
    check("mr_refill_done", 32'(done), 32'd1);
    check("mr_refill_instr", instr, memWord(p));
    @(posedge clk);
    #1;

    // Fresh randomized stream after a clean reset.
    doReset();
    monEn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 3)) << 4) |
          32'($urandom_range(0, 15));
      fetch(a, $urandom_range(0, 2));
    end
    idle(2);
    check("queue_empty", 32'(expQ.size()), 32'd0);
    report();
    $finish;
  end

endmodule
